fb_cmd_writer: RTL and testbench

//  Consumer end of the 54-bit overlay write-command stream {mask[3:0], frame, addr[16:0], pixel[31:0]}.

---
 rtl/fb_pkg.sv | 36 +++
 rtl/fb_cmd_fifo.sv | 46 ++++
 rtl/fb_cmd_writer.sv | 202 ++++++++++++++++++++
 tb/tb_fb_cmd_writer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the 54-bit frame-buffer write-command stream
// {mask[3:0], frame, addr[16:0], pixel[31:0]} and the writer's pass FSM.
package fb_pkg;

    localparam int CMD_W     = 54;
    localparam int MASK_W    = 4;
    localparam int MASK_LSB  = 50;
    localparam int FRAME_BIT = 49;
    localparam int ADDR_LSB  = 32;
    localparam int ADDR_W_IN = 17;
    localparam int PIXEL_W   = 32;

    typedef struct packed {
        logic [MASK_W-1:0]    mask;
        logic                 frame;
        logic [ADDR_W_IN-1:0] addr;
        logic [PIXEL_W-1:0]   pixel;
    } fb_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_STREAM,
        ST_ACK
    } fb_state_t;

    function automatic fb_cmd_t fb_unpack(input logic [CMD_W-1:0] raw);
        fb_cmd_t c;
        c.mask  = raw[MASK_LSB +: MASK_W];
        c.frame = raw[FRAME_BIT];
        c.addr  = raw[ADDR_LSB +: ADDR_W_IN];
        c.pixel = raw[PIXEL_W-1:0];
        return c;
    endfunction

endpackage

// File: rtl/fb_cmd_fifo.sv
// Synchronous command FIFO with exact full/empty flags; the head entry is
// visible combinationally while not empty.
module fb_cmd_fifo #(
    parameter int WIDTH = 54,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit tells a wrapped (full) FIFO from an empty one.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = store[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) store[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fb_cmd_writer.sv
// Frame-buffer command writer: runs producer passes, queues write commands and
// issues masked word writes. Define FB_WR_MERGE_EN to coalesce same-address beats.
module fb_cmd_writer
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 18,
    parameter int FB0_BASE   = 0,
    parameter int FB1_BASE   = 120000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              go,
    output logic              busy,
    output logic              start,
    input  logic              start_ack,
    input  logic              done,
    output logic              done_ack,
    input  logic [CMD_W-1:0]  din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic [3:0]        mem_mask,
    input  logic              mem_ready
);

    localparam logic [ADDR_W-1:0] FB0_W = ADDR_W'(FB0_BASE);
    localparam logic [ADDR_W-1:0] FB1_W = ADDR_W'(FB1_BASE);

    fb_state_t         state;
    fb_state_t         state_next;
    logic              go_pending;
    logic              go_pending_next;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CMD_W-1:0]  fifo_head;
    fb_cmd_t           head;
    logic [ADDR_W-1:0] head_addr;

    logic              slot_valid;
    logic              slot_load;
    logic              retire;

`ifdef FB_WR_MERGE_EN
    logic              slot_issued;
    logic              slot_merge;
    logic              slot_issue;
    logic [ADDR_W_IN:0] slot_key;
`endif

    function automatic logic [ADDR_W-1:0] word_addr(input fb_cmd_t c);
        return (c.frame ? FB1_W : FB0_W) + ADDR_W'(c.addr);
    endfunction

`ifdef FB_WR_MERGE_EN
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_d,
                                                input logic [31:0] new_d,
                                                input logic [3:0]  m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = m[i] ? new_d[8*i +: 8] : old_d[8*i +: 8];
        return r;
    endfunction
`endif

    assign din_ready = ~fifo_full;
    assign fifo_push = din_valid & din_ready;

    fb_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (din),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head      = fb_unpack(fifo_head);
    assign head_addr = word_addr(head);

`ifdef FB_WR_MERGE_EN
    assign mem_we = slot_issued;
`else
    assign mem_we = slot_valid;
`endif
    assign retire = mem_we & mem_ready;

    // Slot control: refill from the FIFO head whenever the slot is free or retiring.
    always_comb begin
        fifo_pop  = 1'b0;
        slot_load = 1'b0;
`ifdef FB_WR_MERGE_EN
        slot_merge = 1'b0;
        slot_issue = 1'b0;
`endif
        if (!slot_valid || retire) begin
            fifo_pop  = ~fifo_empty;
            slot_load = ~fifo_empty && (head.mask != '0);
        end
`ifdef FB_WR_MERGE_EN
        // An unissued slot keeps absorbing same-key beats until something differs or the pass ends.
        else if (!slot_issued) begin
            if (!fifo_empty) begin
                if (head.mask == '0) begin
                    fifo_pop = 1'b1;
                end else if ({head.frame, head.addr} == slot_key) begin
                    fifo_pop   = 1'b1;
                    slot_merge = 1'b1;
                end else begin
                    slot_issue = 1'b1;
                end
            end else if (done) begin
                slot_issue = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_valid <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            mem_mask   <= '0;
`ifdef FB_WR_MERGE_EN
            slot_issued <= 1'b0;
            slot_key    <= '0;
`endif
        end else if (slot_load) begin
            slot_valid <= 1'b1;
            mem_addr   <= head_addr;
            mem_data   <= head.pixel;
            mem_mask   <= head.mask;
`ifdef FB_WR_MERGE_EN
            slot_issued <= 1'b0;
            slot_key    <= {head.frame, head.addr};
`endif
        end else if (retire) begin
            slot_valid <= 1'b0;
`ifdef FB_WR_MERGE_EN
            slot_issued <= 1'b0;
        end else if (slot_merge) begin
            mem_mask <= mem_mask | head.mask;
            mem_data <= merge_bytes(mem_data, head.pixel, head.mask);
        end else if (slot_issue) begin
            slot_issued <= 1'b1;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            go_pending <= 1'b0;
        end else begin
            state      <= state_next;
            go_pending <= go_pending_next;
        end
    end

    // Pass sequencing; done is only looked at in STREAM, so an early done waits there.
    always_comb begin
        state_next      = state;
        go_pending_next = go_pending;
        start           = 1'b0;
        done_ack        = 1'b0;
        busy            = (state != ST_IDLE);
        if (go && state != ST_IDLE)
            go_pending_next = 1'b1;
        case (state)
            ST_IDLE: begin
                if (go || go_pending) begin
                    state_next      = ST_REQ;
                    go_pending_next = 1'b0;
                end
            end
            ST_REQ: begin
                start = 1'b1;
                if (start_ack) state_next = ST_STREAM;
            end
            ST_STREAM: begin
                if (done && fifo_empty && !slot_valid) state_next = ST_ACK;
            end
            ST_ACK: begin
                done_ack   = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fb_cmd_writer.sv
// Self-checking bench for fb_cmd_writer: vector table, corner sequences and
// randomized passes against a field-level reference model.
module tb_fb_cmd_writer;

    localparam int FIFO_DEPTH = 8;
    localparam int ADDR_W     = 18;

    typedef struct packed {
        logic [17:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } wr_t;

    typedef struct {
        logic        frame;
        logic [16:0] addr;
        logic [3:0]  mask;
        logic [31:0] pixel;
        int          exp_n;
        logic [17:0] exp_addr;
    } vec_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              go;
    logic              busy;
    logic              start;
    logic              start_ack;
    logic              done;
    logic              done_ack;
    logic [53:0]       din;
    logic              din_valid;
    logic              din_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic [3:0]        mem_mask;
    logic              mem_ready;

    fb_cmd_writer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W),
        .FB0_BASE   (0),
        .FB1_BASE   (120000)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .go        (go),
        .busy      (busy),
        .start     (start),
        .start_ack (start_ack),
        .done      (done),
        .done_ack  (done_ack),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_mask  (mem_mask),
        .mem_ready (mem_ready)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;
    int ack_cyc = 0;
    int rdy_pct = 100;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Memory side: random ready, write capture and hold-stability tracking.
    wr_t  wr_log[$];
    int   cyc = 0;
    int   last_wr_cyc = 0;
    int   stab_viol = 0;
    logic held = 1'b0;
    wr_t  held_val;

    initial begin
        mem_ready = 1'b0;
        forever begin
            @(negedge clock);
            mem_ready = (rdy_pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < rdy_pct);
        end
    end

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) begin
            held <= 1'b0;
        end else begin
            if (held && !(mem_we && ({mem_addr, mem_data, mem_mask} == held_val)))
                stab_viol <= stab_viol + 1;
            held     <= mem_we && !mem_ready;
            held_val <= {mem_addr, mem_data, mem_mask};
            if (mem_we && mem_ready) begin
                wr_log.push_back({mem_addr, mem_data, mem_mask});
                last_wr_cyc <= cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [53:0] mk(input logic [3:0] m, input logic f,
                                       input logic [16:0] a, input logic [31:0] p);
        return {m, f, a, p};
    endfunction

    // Reference: word address = buffer base + addr, wrapped at 2^18 words.
    function automatic wr_t ref_write(input logic [53:0] c);
        int  base;
        int  word;
        wr_t w;
        base   = c[49] ? 120000 : 0;
        word   = (base + int'(c[48:32])) % 262144;
        w.addr = word[17:0];
        w.data = c[31:0];
        w.mask = c[53:50];
        return w;
    endfunction

    task automatic model_writes(input logic [53:0] b[$], output wr_t e[$]);
        e.delete();
        foreach (b[i])
            if (b[i][53:50] != 4'b0000) e.push_back(ref_write(b[i]));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic start_pass(input string tag);
        int n;
        go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        n = 0;
        while (!start && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_start"}, start, 1);
        start_ack = 1'b1;
        @(negedge clock);
        start_ack = 1'b0;
        chk({tag, "_start_drop"}, start, 0);
    endtask

    task automatic drive_beats(input logic [53:0] beats[$], input int budget, output int sent);
        logic acc;
        sent = 0;
        for (int c = 0; c < budget && sent < beats.size(); c++) begin
            din       = beats[sent];
            din_valid = 1'b1;
            acc       = din_ready;
            @(negedge clock);
            if (acc) sent++;
        end
        din_valid = 1'b0;
    endtask

    task automatic finish_pass(input string tag);
        int n;
        n = 0;
        done = 1'b1;
        while (!done_ack && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_done_ack"}, done_ack, 1);
        ack_cyc = cyc;
        done = 1'b0;
        @(negedge clock);
        chk({tag, "_ack_pulse"}, done_ack, 0);
        chk({tag, "_busy_drop"}, busy, 0);
    endtask

    task automatic check_writes(input string tag, input wr_t exp[$]);
        chk({tag, "_nwr"}, wr_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < wr_log.size(); i++) begin
            chk({tag, "_addr"}, wr_log[i].addr, exp[i].addr);
            chk({tag, "_data"}, wr_log[i].data, exp[i].data);
            chk({tag, "_mask"}, wr_log[i].mask, exp[i].mask);
        end
        wr_log.delete();
    endtask

    task automatic run_pass(input string tag, input logic [53:0] beats[$]);
        wr_t exp[$];
        int  sent;
        start_pass(tag);
        drive_beats(beats, 4000, sent);
        chk({tag, "_sent"}, sent, beats.size());
        finish_pass(tag);
        model_writes(beats, exp);
        if (exp.size() > 0) chk({tag, "_ack_after_wr"}, ack_cyc > last_wr_cyc, 1);
        check_writes(tag, exp);
    endtask

    initial begin
        vec_t        vecs[6];
        logic [53:0] q[$];
        logic [53:0] rest[$];
        wr_t         exp[$];
        int          sent;
        int          n;
        logic [17:0] prev_key;

        reset = 1'b1; go = 1'b0; start_ack = 1'b0; done = 1'b0;
        din = '0; din_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("rst_busy",     busy,      0);
        chk("rst_start",    start,     0);
        chk("rst_done_ack", done_ack,  0);
        chk("rst_mem_we",   mem_we,    0);
        chk("rst_mem_addr", mem_addr,  0);
        chk("rst_mem_data", mem_data,  0);
        chk("rst_mem_mask", mem_mask,  0);
        chk("rst_din_rdy",  din_ready, 1);

        // Single-beat vectors: address arithmetic and mask handling.
        vecs[0] = '{1'b1, 17'h1D4BF, 4'b1111, 32'hDEADBEEF, 1, 18'd239999};
        vecs[1] = '{1'b0, 17'd5,     4'b0001, 32'h11223344, 1, 18'd5};
        vecs[2] = '{1'b1, 17'd0,     4'b1010, 32'hA5A5A5A5, 1, 18'd120000};
        vecs[3] = '{1'b0, 17'h1FFFF, 4'b0100, 32'h00FF0000, 1, 18'd131071};
        vecs[4] = '{1'b1, 17'h1FFFF, 4'b1000, 32'h7E000000, 1, 18'd251071};
        vecs[5] = '{1'b0, 17'd16,    4'b0000, 32'hFFFFFFFF, 0, 18'd0};
        for (int v = 0; v < 6; v++) begin
            q.delete();
            q.push_back(mk(vecs[v].mask, vecs[v].frame, vecs[v].addr, vecs[v].pixel));
            start_pass("vec");
            drive_beats(q, 100, sent);
            finish_pass("vec");
            chk("vec_nwr", wr_log.size(), vecs[v].exp_n);
            if (vecs[v].exp_n == 1 && wr_log.size() == 1) begin
                chk("vec_addr", wr_log[0].addr, vecs[v].exp_addr);
                chk("vec_data", wr_log[0].data, vecs[v].pixel);
                chk("vec_mask", wr_log[0].mask, vecs[v].mask);
            end
            wr_log.delete();
        end

        // Four sequential single-lane writes.
        q.delete();
        for (int i = 0; i < 4; i++) q.push_back(mk(4'b0001, 1'b0, 17'(100 + i), 32'h02020202));
        run_pass("seq4", q);

        // Reset mid-STREAM with three beats queued and one held in the slot.
        rdy_pct = 0;
        q.delete();
        for (int i = 0; i < 4; i++) q.push_back(mk(4'b1111, 1'b0, 17'(500 + i), 32'hBAD00000 + i));
        start_pass("mid_rst");
        drive_beats(q, 20, sent);
        @(negedge clock);
        chk("mid_rst_no_wr", wr_log.size(), 0);
        do_reset();
        chk("mid_rst_busy",   busy,      0);
        chk("mid_rst_mem_we", mem_we,    0);
        chk("mid_rst_din_rdy", din_ready, 1);
        rdy_pct = 100;
        wr_log.delete();
        q.delete();
        q.push_back(mk(4'b0011, 1'b0, 17'd600, 32'h0000C0DE));
        q.push_back(mk(4'b1100, 1'b1, 17'd601, 32'hF00D0000));
        run_pass("post_rst", q);

        // Backpressure: memory stalled for 20 cycles while beats stream in.
        rdy_pct = 0;
        q.delete();
        for (int i = 0; i < 12; i++) q.push_back(mk(4'b1111, 1'(i), 17'(300 + i), 32'h01010101 * (i + 1)));
        start_pass("stall");
        drive_beats(q, 20, sent);
        chk("stall_accepted", sent, FIFO_DEPTH + 1);
        chk("stall_din_rdy",  din_ready, 0);
        chk("stall_no_wr",    wr_log.size(), 0);
        rdy_pct = 100;
        rest.delete();
        for (int i = sent; i < q.size(); i++) rest.push_back(q[i]);
        drive_beats(rest, 200, n);
        chk("stall_rest_sent", n, rest.size());
        finish_pass("stall");
        model_writes(q, exp);
        check_writes("stall", exp);
        chk("stall_stable", stab_viol, 0);

        // Zero-mask drop, plus go during STREAM queues exactly one more pass.
        q.delete();
        q.push_back(mk(4'b0001, 1'b0, 17'd10, 32'h000000E1));
        q.push_back(mk(4'b0000, 1'b0, 17'd11, 32'hFFFFFFFF));
        q.push_back(mk(4'b1000, 1'b0, 17'd12, 32'hE3000000));
        start_pass("drop");
        drive_beats(q, 100, sent);
        go = 1'b1; @(negedge clock); go = 1'b0;
        go = 1'b1; @(negedge clock); go = 1'b0;
        finish_pass("drop");
        model_writes(q, exp);
        chk("drop_model_n", exp.size(), 2);
        check_writes("drop", exp);
        n = 0;
        while (!start && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk("pend_start", start, 1);
        chk("pend_latency", n <= 2, 1);
        start_ack = 1'b1; @(negedge clock); start_ack = 1'b0;
        finish_pass("pend");
        repeat (5) @(negedge clock);
        chk("pend_no_third", busy, 0);
        chk("pend_nwr", wr_log.size(), 0);

        // Four byte lanes to the same word.
        q.delete();
        q.push_back(mk(4'b0001, 1'b0, 17'd200, 32'h000000AA));
        q.push_back(mk(4'b0010, 1'b0, 17'd200, 32'h0000BB00));
        q.push_back(mk(4'b0100, 1'b0, 17'd200, 32'h00CC0000));
        q.push_back(mk(4'b1000, 1'b0, 17'd200, 32'hDD000000));
        start_pass("lanes");
        drive_beats(q, 100, sent);
        finish_pass("lanes");
`ifdef FB_WR_MERGE_EN
        exp.delete();
        exp.push_back('{18'd200, 32'hDDCCBBAA, 4'b1111});
`else
        model_writes(q, exp);
`endif
        check_writes("lanes", exp);

        // Randomized passes with random memory readiness.
        for (int p = 0; p < 6; p++) begin
            rdy_pct = 30 + int'($urandom_range(0, 70));
            q.delete();
            prev_key = 18'h3FFFF;
            n = int'($urandom_range(1, 15));
            for (int i = 0; i < n; i++) begin
                logic [3:0]  m;
                logic        f;
                logic [16:0] a;
                m = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
                f = 1'($urandom_range(0, 1));
                a = 17'($urandom_range(0, 131071));
                if (m != 4'b0000 && {f, a} == prev_key) a = a + 17'd1;
                if (m != 4'b0000) prev_key = {f, a};
                q.push_back(mk(m, f, a, $urandom));
            end
            run_pass("rand", q);
        end
        rdy_pct = 100;
        chk("final_stable", stab_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
